// File: rtl/content_loss_accum.sv
// content_loss_accum
// Accumulates TILES per-tile content-loss values into one saturating frame
// total. The total and its sticky saturation flag are offered to the
// optimiser/control logic over a valid/ready handshake.
// Optional build macro: CONTENT_LOSS_MAX_EN adds tile_loss_max, the largest
// tile accepted in the frame.
//
// state | meaning
// IDLE  | waiting for start; no tiles accepted, no result offered
// ACCUM | tile_ready high; summing accepted tiles until TILES are taken
// DONE  | frame_valid high; result held until frame_ready
module content_loss_accum #(
  parameter int LOSS_W = 16,
  parameter int TILES  = 64,
  parameter int ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LOSS_W-1:0] tile_loss,
  input  logic              tile_valid,
  output logic              tile_ready,
  output logic [ACC_W-1:0]  frame_loss,
  output logic              frame_sat,
  output logic              frame_valid,
  input  logic              frame_ready,
  output logic              busy
`ifdef CONTENT_LOSS_MAX_EN
  ,
  output logic [LOSS_W-1:0] tile_loss_max
`endif
);

  localparam int CNT_W = (TILES > 1) ? $clog2(TILES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TILES - 1);

  // One-hot so that tile_ready / frame_valid come straight off a flop.
  typedef enum logic [2:0] {
    IDLE  = 3'b001,
    ACCUM = 3'b010,
    DONE  = 3'b100
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ACC_W-1:0]  acc;
  logic              sat;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W:0]    sum;
  logic [ACC_W-1:0]  acc_nxt;
  logic              sat_nxt;
  logic              accept;
  logic              last;
  logic              begin_frame;

  assign accept      = tile_valid & tile_ready;
  assign last        = (cnt == LAST_CNT);
  assign begin_frame = (state == IDLE) & start;

  // Saturating add: the extra carry bit means the sum can never wrap.
  always_comb begin
    sum     = {1'b0, acc} + {{(ACC_W + 1 - LOSS_W){1'b0}}, tile_loss};
    sat_nxt = sat | sum[ACC_W];
    acc_nxt = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (accept && last) state_nxt = DONE;
      DONE:    if (frame_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from the one-hot state bits.
  always_comb begin
    tile_ready  = (state == ACCUM);
    frame_valid = (state == DONE);
    busy        = (state == ACCUM) | (state == DONE);
  end

  // Accumulator, tile counter and frame result; the result only changes on
  // the final accept, so it is stable through DONE and held afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      sat        <= 1'b0;
      cnt        <= '0;
      frame_loss <= '0;
      frame_sat  <= 1'b0;
    end else if (begin_frame) begin
      acc <= '0;
      sat <= 1'b0;
      cnt <= '0;
    end else if (accept) begin
      acc <= acc_nxt;
      sat <= sat_nxt;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        frame_loss <= acc_nxt;
        frame_sat  <= sat_nxt;
      end
    end
  end

`ifdef CONTENT_LOSS_MAX_EN
  logic [LOSS_W-1:0] max_run;
  logic [LOSS_W-1:0] max_nxt;

  assign max_nxt = (tile_loss > max_run) ? tile_loss : max_run;

  // Running maximum; published with frame_loss and held until the next start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      max_run       <= '0;
      tile_loss_max <= '0;
    end else if (begin_frame) begin
      max_run       <= '0;
      tile_loss_max <= '0;
    end else if (accept) begin
      max_run <= max_nxt;
      if (last) tile_loss_max <= max_nxt;
    end
  end
`endif

endmodule
